icache_fetch: RTL and testbench



---
 rtl/icache_fetch_if.sv | 63 ++++++
 rtl/icache_fetch.sv | 141 ++++++++++++++
 tb/tb_icache_fetch.sv | 508 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_fetch_if.sv
// Fetch-stage bus bundle: scheduler input, icache request/response, decode output, status.
// slave is the fetch stage's view; master is the surrounding pipeline's view.
interface icache_fetch_if #(
    parameter int unsigned NUM_WARPS   = 4,
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned UUID_WIDTH  = 44
);
    localparam int unsigned NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    logic                   sched_valid;
    logic                   sched_ready;
    logic [NW_WIDTH-1:0]    sched_wid;
    logic [NUM_THREADS-1:0] sched_tmask;
    logic [XLEN-1:0]        sched_pc;
    logic [UUID_WIDTH-1:0]  sched_uuid;
    logic [NUM_WARPS-1:0]   ibuf_full;

    logic                   icache_req_valid;
    logic                   icache_req_ready;
    logic [XLEN-3:0]        icache_req_addr;
    logic [NW_WIDTH-1:0]    icache_req_tag;

    logic                   icache_rsp_valid;
    logic                   icache_rsp_ready;
    logic [31:0]            icache_rsp_data;
    logic [NW_WIDTH-1:0]    icache_rsp_tag;

    logic                   fetch_valid;
    logic                   fetch_ready;
    logic [NW_WIDTH-1:0]    fetch_wid;
    logic [NUM_THREADS-1:0] fetch_tmask;
    logic [XLEN-1:0]        fetch_pc;
    logic [UUID_WIDTH-1:0]  fetch_uuid;
    logic [31:0]            fetch_instr;

    logic                   err;
    logic                   busy;

    modport slave (
        input  sched_valid, sched_wid, sched_tmask, sched_pc, sched_uuid, ibuf_full,
        output sched_ready,
        output icache_req_valid, icache_req_addr, icache_req_tag,
        input  icache_req_ready,
        input  icache_rsp_valid, icache_rsp_data, icache_rsp_tag,
        output icache_rsp_ready,
        output fetch_valid, fetch_wid, fetch_tmask, fetch_pc, fetch_uuid, fetch_instr,
        input  fetch_ready,
        output err, busy
    );

    modport master (
        output sched_valid, sched_wid, sched_tmask, sched_pc, sched_uuid, ibuf_full,
        input  sched_ready,
        input  icache_req_valid, icache_req_addr, icache_req_tag,
        output icache_req_ready,
        output icache_rsp_valid, icache_rsp_data, icache_rsp_tag,
        input  icache_rsp_ready,
        input  fetch_valid, fetch_wid, fetch_tmask, fetch_pc, fetch_uuid, fetch_instr,
        output fetch_ready,
        input  err, busy
    );
endinterface

// File: rtl/icache_fetch.sv
// Instruction fetch stage: issues one icache word fetch per scheduled warp, parks the
// warp's metadata until the tagged response returns, then emits the fetched instruction.
// At most one fetch in flight per warp; responses may return in any order.
module icache_fetch #(
    parameter int unsigned NUM_WARPS   = 4,
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned UUID_WIDTH  = 44
) (
    input logic           clk,
    input logic           reset,
    icache_fetch_if.slave bus
);
    localparam int unsigned NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    logic                   req_valid_q;
    logic [XLEN-3:0]        req_addr_q;
    logic [NW_WIDTH-1:0]    req_tag_q;

    logic [NUM_WARPS-1:0]   pending_q, pending_d;
    logic [NUM_THREADS-1:0] meta_tmask_q [NUM_WARPS];
    logic [XLEN-1:0]        meta_pc_q    [NUM_WARPS];
    logic [UUID_WIDTH-1:0]  meta_uuid_q  [NUM_WARPS];

    logic                   fetch_valid_q;
    logic [NW_WIDTH-1:0]    fetch_wid_q;
    logic [NUM_THREADS-1:0] fetch_tmask_q;
    logic [XLEN-1:0]        fetch_pc_q;
    logic [UUID_WIDTH-1:0]  fetch_uuid_q;
    logic [31:0]            fetch_instr_q;

    logic                   err_q;

    logic sched_fire, req_fire, rsp_fire, rsp_hit, fetch_fire;

    // Request slot is free if empty or draining this cycle (no bubble between requests).
    assign bus.sched_ready = (~req_valid_q | bus.icache_req_ready)
                           & ~pending_q[bus.sched_wid]
                           & ~bus.ibuf_full[bus.sched_wid];
    assign bus.icache_rsp_ready = ~fetch_valid_q | bus.fetch_ready;

    assign sched_fire = bus.sched_valid & bus.sched_ready;
    assign req_fire   = req_valid_q & bus.icache_req_ready;
    assign rsp_fire   = bus.icache_rsp_valid & bus.icache_rsp_ready;
    assign rsp_hit    = rsp_fire & pending_q[bus.icache_rsp_tag];
    assign fetch_fire = fetch_valid_q & bus.fetch_ready;

    assign bus.icache_req_valid = req_valid_q;
    assign bus.icache_req_addr  = req_addr_q;
    assign bus.icache_req_tag   = req_tag_q;

    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_wid   = fetch_wid_q;
    assign bus.fetch_tmask = fetch_tmask_q;
    assign bus.fetch_pc    = fetch_pc_q;
    assign bus.fetch_uuid  = fetch_uuid_q;
    assign bus.fetch_instr = fetch_instr_q;

    assign bus.err  = err_q;
    assign bus.busy = req_valid_q | fetch_valid_q | (|pending_q);

    // Request register: load on accept, otherwise drop once the cache takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_tag_q   <= '0;
        end else if (sched_fire) begin
            req_valid_q <= 1'b1;
            req_addr_q  <= bus.sched_pc[XLEN-1:2];
            req_tag_q   <= bus.sched_wid;
        end else if (req_fire) begin
            req_valid_q <= 1'b0;
        end
    end

    // Pending set/clear never target the same warp in one cycle (accept needs pending=0).
    always_comb begin
        pending_d = pending_q;
        if (rsp_hit) begin
            pending_d[bus.icache_rsp_tag] = 1'b0;
        end
        if (sched_fire) begin
            pending_d[bus.sched_wid] = 1'b1;
        end
    end

    // Pending flags per warp.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Metadata table, written at accept, read when the matching response returns.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_WARPS; i++) begin
                meta_tmask_q[i] <= '0;
                meta_pc_q[i]    <= '0;
                meta_uuid_q[i]  <= '0;
            end
        end else if (sched_fire) begin
            meta_tmask_q[bus.sched_wid] <= bus.sched_tmask;
            meta_pc_q[bus.sched_wid]    <= bus.sched_pc;
            meta_uuid_q[bus.sched_wid]  <= bus.sched_uuid;
        end
    end

    // Output register: load on a matching response, clear when decode takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_valid_q <= 1'b0;
            fetch_wid_q   <= '0;
            fetch_tmask_q <= '0;
            fetch_pc_q    <= '0;
            fetch_uuid_q  <= '0;
            fetch_instr_q <= '0;
        end else if (rsp_hit) begin
            fetch_valid_q <= 1'b1;
            fetch_wid_q   <= bus.icache_rsp_tag;
            fetch_tmask_q <= meta_tmask_q[bus.icache_rsp_tag];
            fetch_pc_q    <= meta_pc_q[bus.icache_rsp_tag];
            fetch_uuid_q  <= meta_uuid_q[bus.icache_rsp_tag];
            fetch_instr_q <= bus.icache_rsp_data;
        end else if (fetch_fire) begin
            fetch_valid_q <= 1'b0;
        end
    end

    // Sticky error: a response arrived for a warp with nothing in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (rsp_fire & ~rsp_hit) begin
            err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_icache_fetch.sv
// Self-checking bench for icache_fetch: directed scenarios plus a randomized run scored
// against a transaction-level model (pending set, metadata table, cache reorder pool).
module tb_icache_fetch;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    icache_fetch_if bus ();

    icache_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.sched_valid      = 1'b0;
        bus.sched_wid        = '0;
        bus.sched_tmask      = '0;
        bus.sched_pc         = '0;
        bus.sched_uuid       = '0;
        bus.ibuf_full        = '0;
        bus.icache_req_ready = 1'b1;
        bus.icache_rsp_valid = 1'b0;
        bus.icache_rsp_data  = '0;
        bus.icache_rsp_tag   = '0;
        bus.fetch_ready      = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drive_sched(input int w, input logic [31:0] pc, input logic [43:0] uuid);
        bus.sched_valid = 1'b1;
        bus.sched_wid   = 2'(w);
        bus.sched_pc    = pc;
        bus.sched_tmask = 4'(1 << w);
        bus.sched_uuid  = uuid;
    endtask

    task automatic drive_rsp(input int tag, input logic [31:0] data);
        bus.icache_rsp_valid = 1'b1;
        bus.icache_rsp_tag   = 2'(tag);
        bus.icache_rsp_data  = data;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (bus.icache_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_req_valid got %b exp 0", bus.icache_req_valid);
        end
        n_checks++;
        if (bus.fetch_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_fetch_valid got %b exp 0", bus.fetch_valid);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy);
        end
        n_checks++;
        if (bus.err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err got %b exp 0", bus.err);
        end
        n_checks++;
        if (bus.sched_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_sched_ready got %b exp 1", bus.sched_ready);
        end
    endtask

    task automatic test_single_fetch();
        do_reset();
        drive_sched(1, 32'h8000_0000, 44'd7);
        bus.sched_tmask = 4'b0001;
        #1;
        n_checks++;
        if (bus.sched_ready !== 1'b1) begin
            n_fail++; $display("FAIL single_accept got %b exp 1", bus.sched_ready);
        end
        step();
        bus.sched_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.icache_req_valid !== 1'b1 || bus.icache_req_addr !== 30'h2000_0000 ||
            bus.icache_req_tag !== 2'd1) begin
            n_fail++;
            $display("FAIL single_req got v=%b addr=%h tag=%0d exp v=1 addr=20000000 tag=1",
                     bus.icache_req_valid, bus.icache_req_addr, bus.icache_req_tag);
        end
        step();
        step();
        drive_rsp(1, 32'h0000_0013);
        #1;
        n_checks++;
        if (bus.icache_rsp_ready !== 1'b1) begin
            n_fail++; $display("FAIL single_rsp_ready got %b exp 1", bus.icache_rsp_ready);
        end
        step();
        bus.icache_rsp_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_wid !== 2'd1 || bus.fetch_pc !== 32'h8000_0000
            || bus.fetch_instr !== 32'h13 || bus.fetch_uuid !== 44'd7
            || bus.fetch_tmask !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_fetch got v=%b wid=%0d pc=%h instr=%h uuid=%0d tm=%b exp 1/1/80000000/13/7/0001",
                     bus.fetch_valid, bus.fetch_wid, bus.fetch_pc, bus.fetch_instr,
                     bus.fetch_uuid, bus.fetch_tmask);
        end
        step();
        #1;
        n_checks++;
        if (bus.fetch_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle got fv=%b busy=%b exp 0/0", bus.fetch_valid, bus.busy);
        end
    endtask

    task automatic test_same_warp_block();
        do_reset();
        drive_sched(2, 32'h200, 44'd20);
        step();
        drive_sched(2, 32'h204, 44'd21);
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if (bus.sched_ready !== 1'b0) begin
                n_fail++; $display("FAIL block_wid2 got %b exp 0", bus.sched_ready);
            end
            step();
        end
        drive_sched(3, 32'h300, 44'd30);
        #1;
        n_checks++;
        if (bus.sched_ready !== 1'b1) begin
            n_fail++; $display("FAIL block_wid3_ok got %b exp 1", bus.sched_ready);
        end
        step();
        drive_sched(2, 32'h204, 44'd21);
        drive_rsp(2, 32'hAAAA_0002);
        #1;
        n_checks++;
        if (bus.sched_ready !== 1'b0) begin
            n_fail++; $display("FAIL block_rsp_cycle got %b exp 0", bus.sched_ready);
        end
        step();
        bus.icache_rsp_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.sched_ready !== 1'b1) begin
            n_fail++; $display("FAIL block_reaccept got %b exp 1", bus.sched_ready);
        end
        n_checks++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== 32'h200 || bus.fetch_uuid !== 44'd20) begin
            n_fail++;
            $display("FAIL block_first_out got v=%b pc=%h uuid=%0d exp 1/200/20",
                     bus.fetch_valid, bus.fetch_pc, bus.fetch_uuid);
        end
        step();
        bus.sched_valid = 1'b0;
        drive_rsp(3, 32'hAAAA_0003);
        #1;
        n_checks++;
        if (bus.icache_req_tag !== 2'd2 || bus.icache_req_addr !== 30'h81) begin
            n_fail++;
            $display("FAIL block_second_req got tag=%0d addr=%h exp 2/81",
                     bus.icache_req_tag, bus.icache_req_addr);
        end
        step();
        drive_rsp(2, 32'hAAAA_0022);
        #1;
        n_checks++;
        if (bus.fetch_wid !== 2'd3 || bus.fetch_pc !== 32'h300) begin
            n_fail++;
            $display("FAIL block_wid3_out got wid=%0d pc=%h exp 3/300", bus.fetch_wid, bus.fetch_pc);
        end
        step();
        bus.icache_rsp_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.fetch_wid !== 2'd2 || bus.fetch_pc !== 32'h204 || bus.fetch_uuid !== 44'd21 ||
            bus.fetch_instr !== 32'hAAAA_0022) begin
            n_fail++;
            $display("FAIL block_second_out got wid=%0d pc=%h uuid=%0d instr=%h exp 2/204/21/aaaa0022",
                     bus.fetch_wid, bus.fetch_pc, bus.fetch_uuid, bus.fetch_instr);
        end
    endtask

    task automatic test_out_of_order();
        int ord [3];
        ord = '{2, 0, 1};
        do_reset();
        for (int w = 0; w < 3; w++) begin
            drive_sched(w, 32'h1000 + 32'(w * 16), 44'(100 + w));
            #1;
            n_checks++;
            if (bus.sched_ready !== 1'b1) begin
                n_fail++; $display("FAIL ooo_accept%0d got %b exp 1", w, bus.sched_ready);
            end
            step();
        end
        bus.sched_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_rsp(ord[i], 32'hC0DE_0000 + 32'(ord[i]));
            step();
            bus.icache_rsp_valid = 1'b0;
            #1;
            n_checks++;
            if (bus.fetch_valid !== 1'b1 || bus.fetch_wid !== 2'(ord[i]) ||
                bus.fetch_pc !== 32'h1000 + 32'(ord[i] * 16) ||
                bus.fetch_uuid !== 44'(100 + ord[i]) ||
                bus.fetch_instr !== 32'hC0DE_0000 + 32'(ord[i])) begin
                n_fail++;
                $display("FAIL ooo_out%0d got v=%b wid=%0d pc=%h uuid=%0d instr=%h exp wid=%0d",
                         i, bus.fetch_valid, bus.fetch_wid, bus.fetch_pc, bus.fetch_uuid,
                         bus.fetch_instr, ord[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.fetch_ready = 1'b0;
        drive_sched(0, 32'h40, 44'd40);
        step();
        drive_sched(1, 32'h50, 44'd50);
        step();
        bus.sched_valid = 1'b0;
        drive_rsp(0, 32'hD000_0000);
        #1;
        n_checks++;
        if (bus.icache_rsp_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_first_ready got %b exp 1", bus.icache_rsp_ready);
        end
        step();
        drive_rsp(1, 32'hD000_0001);
        #1;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (bus.icache_rsp_ready !== 1'b0 || bus.fetch_valid !== 1'b1 ||
                bus.fetch_wid !== 2'd0 || bus.fetch_instr !== 32'hD000_0000) begin
                n_fail++;
                $display("FAIL bp_hold%0d got rr=%b fv=%b wid=%0d instr=%h exp 0/1/0/d0000000",
                         k, bus.icache_rsp_ready, bus.fetch_valid, bus.fetch_wid, bus.fetch_instr);
            end
            step();
            #1;
        end
        bus.fetch_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.icache_rsp_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release got %b exp 1", bus.icache_rsp_ready);
        end
        step();
        bus.icache_rsp_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_wid !== 2'd1 || bus.fetch_pc !== 32'h50 ||
            bus.fetch_instr !== 32'hD000_0001) begin
            n_fail++;
            $display("FAIL bp_second got v=%b wid=%0d pc=%h instr=%h exp 1/1/50/d0000001",
                     bus.fetch_valid, bus.fetch_wid, bus.fetch_pc, bus.fetch_instr);
        end
        step();
        #1;
        n_checks++;
        if (bus.fetch_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_idle got fv=%b busy=%b exp 0/0", bus.fetch_valid, bus.busy);
        end
    endtask

    task automatic test_ibuf_and_stall();
        do_reset();
        bus.ibuf_full = 4'b1000;
        for (int w = 0; w < 4; w++) begin
            bus.sched_wid = 2'(w);
            #1;
            n_checks++;
            if (bus.sched_ready !== (w != 3)) begin
                n_fail++; $display("FAIL ibuf_wid%0d got %b exp %b", w, bus.sched_ready, (w != 3));
            end
        end
        step();
        bus.ibuf_full = '0;
        bus.icache_req_ready = 1'b0;
        drive_sched(0, 32'h400, 44'd1);
        step();
        drive_sched(1, 32'h800, 44'd2);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (bus.sched_ready !== 1'b0 || bus.icache_req_valid !== 1'b1 ||
                bus.icache_req_addr !== 30'h100 || bus.icache_req_tag !== 2'd0) begin
                n_fail++;
                $display("FAIL stall_hold%0d got sr=%b rv=%b addr=%h tag=%0d exp 0/1/100/0",
                         k, bus.sched_ready, bus.icache_req_valid, bus.icache_req_addr,
                         bus.icache_req_tag);
            end
            step();
        end
        bus.icache_req_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.sched_ready !== 1'b1) begin
            n_fail++; $display("FAIL stall_release got %b exp 1", bus.sched_ready);
        end
        step();
        bus.sched_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.icache_req_valid !== 1'b1 || bus.icache_req_tag !== 2'd1 ||
            bus.icache_req_addr !== 30'h200) begin
            n_fail++;
            $display("FAIL stall_reload got v=%b tag=%0d addr=%h exp 1/1/200",
                     bus.icache_req_valid, bus.icache_req_tag, bus.icache_req_addr);
        end
    endtask

    task automatic test_spurious_and_reset();
        do_reset();
        drive_rsp(2, 32'hBAD0_0002);
        #1;
        n_checks++;
        if (bus.icache_rsp_ready !== 1'b1) begin
            n_fail++; $display("FAIL spur_ready got %b exp 1", bus.icache_rsp_ready);
        end
        step();
        bus.icache_rsp_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.err !== 1'b1 || bus.fetch_valid !== 1'b0) begin
            n_fail++; $display("FAIL spur_drop got err=%b fv=%b exp 1/0", bus.err, bus.fetch_valid);
        end
        step();
        step();
        #1;
        n_checks++;
        if (bus.err !== 1'b1) begin
            n_fail++; $display("FAIL spur_sticky got %b exp 1", bus.err);
        end
        drive_sched(0, 32'h600, 44'd60);
        step();
        bus.sched_valid = 1'b0;
        step();
        #1;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL pend_busy got %b exp 1", bus.busy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.sched_wid = 2'd0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.sched_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_flight got busy=%b err=%b sr=%b exp 0/0/1",
                     bus.busy, bus.err, bus.sched_ready);
        end
        drive_rsp(0, 32'h0000_0600);
        step();
        bus.icache_rsp_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.err !== 1'b1 || bus.fetch_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_stale got err=%b fv=%b exp 1/0", bus.err, bus.fetch_valid);
        end
    endtask

    typedef struct {
        logic [1:0]  tag;
        logic [29:0] addr;
    } creq_t;

    task automatic test_random();
        bit          m_pending [4];
        logic [3:0]  m_tmask   [4];
        logic [31:0] m_pc      [4];
        logic [43:0] m_uuid    [4];
        bit          m_req_valid, m_out_valid, m_err, any_pend;
        logic [29:0] m_req_addr;
        logic [1:0]  m_req_tag, m_out_wid;
        logic [3:0]  m_out_tmask;
        logic [31:0] m_out_pc, m_out_instr;
        logic [43:0] m_out_uuid;
        creq_t       cq [$];
        bit          rsp_active, exp_sready, exp_rready, acc, rfire, pfire, ffire;
        int          rsp_idx, w, t;
        do_reset();
        for (int i = 0; i < 4; i++) m_pending[i] = 0;
        m_req_valid = 0; m_out_valid = 0; m_err = 0; rsp_active = 0; rsp_idx = 0;
        m_req_addr = '0; m_req_tag = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.ibuf_full        = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            bus.icache_req_ready = ($urandom_range(0, 3) != 0);
            bus.fetch_ready      = ($urandom_range(0, 3) != 0);
            bus.sched_valid      = 1'($urandom_range(0, 1));
            bus.sched_wid        = 2'($urandom_range(0, 3));
            bus.sched_pc         = $urandom;
            bus.sched_tmask      = 4'($urandom);
            bus.sched_uuid       = {12'($urandom), 32'($urandom)};
            if (!rsp_active && cq.size() > 0 && $urandom_range(0, 2) == 0) begin
                rsp_idx = $urandom_range(0, cq.size() - 1);
                rsp_active = 1;
            end
            bus.icache_rsp_valid = rsp_active;
            if (rsp_active) begin
                bus.icache_rsp_tag  = cq[rsp_idx].tag;
                bus.icache_rsp_data = {cq[rsp_idx].addr, 2'b00} ^ 32'h5A5A_1234;
            end
            #1;
            w = int'(bus.sched_wid);
            exp_sready = (!m_req_valid || bus.icache_req_ready) && !m_pending[w] &&
                         !bus.ibuf_full[w];
            exp_rready = !m_out_valid || bus.fetch_ready;
            any_pend = m_pending[0] | m_pending[1] | m_pending[2] | m_pending[3];
            n_checks++;
            if (bus.sched_ready !== exp_sready || bus.icache_rsp_ready !== exp_rready) begin
                n_fail++;
                $display("FAIL rnd_ready cyc %0d got sr=%b rr=%b exp %b/%b",
                         cyc, bus.sched_ready, bus.icache_rsp_ready, exp_sready, exp_rready);
            end
            n_checks++;
            if (bus.icache_req_valid !== m_req_valid || (m_req_valid &&
                (bus.icache_req_addr !== m_req_addr || bus.icache_req_tag !== m_req_tag))) begin
                n_fail++;
                $display("FAIL rnd_req cyc %0d got v=%b addr=%h tag=%0d exp %b/%h/%0d", cyc,
                         bus.icache_req_valid, bus.icache_req_addr, bus.icache_req_tag,
                         m_req_valid, m_req_addr, m_req_tag);
            end
            n_checks++;
            if (bus.fetch_valid !== m_out_valid || (m_out_valid &&
                (bus.fetch_wid !== m_out_wid || bus.fetch_pc !== m_out_pc ||
                 bus.fetch_tmask !== m_out_tmask || bus.fetch_uuid !== m_out_uuid ||
                 bus.fetch_instr !== m_out_instr))) begin
                n_fail++;
                $display("FAIL rnd_fetch cyc %0d got v=%b wid=%0d pc=%h instr=%h exp %b/%0d/%h/%h",
                         cyc, bus.fetch_valid, bus.fetch_wid, bus.fetch_pc, bus.fetch_instr,
                         m_out_valid, m_out_wid, m_out_pc, m_out_instr);
            end
            n_checks++;
            if (bus.busy !== (m_req_valid | m_out_valid | any_pend) || bus.err !== m_err) begin
                n_fail++;
                $display("FAIL rnd_status cyc %0d got busy=%b err=%b exp %b/%b", cyc, bus.busy,
                         bus.err, (m_req_valid | m_out_valid | any_pend), m_err);
            end
            acc   = bus.sched_valid && exp_sready;
            rfire = m_req_valid && bus.icache_req_ready;
            pfire = rsp_active && exp_rready;
            ffire = m_out_valid && bus.fetch_ready;
            if (pfire) begin
                t = int'(cq[rsp_idx].tag);
                if (m_pending[t]) begin
                    m_out_valid = 1; m_out_wid = 2'(t); m_out_pc = m_pc[t];
                    m_out_tmask = m_tmask[t]; m_out_uuid = m_uuid[t];
                    m_out_instr = {cq[rsp_idx].addr, 2'b00} ^ 32'h5A5A_1234;
                    m_pending[t] = 0;
                end else begin
                    m_err = 1;
                end
                cq.delete(rsp_idx);
                rsp_active = 0;
            end else if (ffire) begin
                m_out_valid = 0;
            end
            if (rfire) cq.push_back('{tag: m_req_tag, addr: m_req_addr});
            if (acc) begin
                m_req_valid = 1; m_req_addr = bus.sched_pc[31:2]; m_req_tag = bus.sched_wid;
                m_pending[w] = 1; m_pc[w] = bus.sched_pc; m_tmask[w] = bus.sched_tmask;
                m_uuid[w] = bus.sched_uuid;
            end else if (rfire) begin
                m_req_valid = 0;
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_same_warp_block();
        test_out_of_order();
        test_backpressure();
        test_ibuf_and_stall();
        test_spurious_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
